// File: rtl/pcoeff_pkg.sv
// Shared widths and the result payload carried from the permutation pipeline to the host path.
package pcoeff_pkg;

  localparam int unsigned PCOEFF_SUM_W   = 48;
  localparam int unsigned PCOEFF_COUNT_W = 13;
  localparam int unsigned RESULT_W       = 62;

  typedef struct packed {
    logic                      ecc;
    logic [PCOEFF_COUNT_W-1:0] count;
    logic [PCOEFF_SUM_W-1:0]   sum;
  } pcoeff_result_t;

endpackage

// File: rtl/pcoeff_result_fifo.sv
// First-word-fall-through FIFO: the head entry is always presented on o_data while o_valid.
module pcoeff_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 78
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_push;
  logic             w_pop;

  // Protect against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push && (r_occ != OCC_W'(DEPTH));
  assign w_pop  = i_pop && (r_occ != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

  assign o_valid     = (r_occ != '0);
  assign o_data      = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;

endmodule

// File: rtl/pcoeff_result_collector.sv
// Drains upstream results into a FWFT FIFO with sequence tags and running totals.
// Define PCOEFF_ECC_STICKY_EN to add the eccErrorSticky/eccErrorCount statistics ports.
module pcoeff_result_collector
  import pcoeff_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16,
  parameter int unsigned TOT_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          resultsAvailable,
  input  logic [PCOEFF_SUM_W-1:0]       pcoeffSum,
  input  logic [PCOEFF_COUNT_W-1:0]     pcoeffCount,
  input  logic                          eccStatus,
  output logic                          grabResults,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [SEQ_W+RESULT_W-1:0]     outData,
  input  logic                          clearTotals,
  output logic [TOT_W-1:0]              totalSum,
  output logic [31:0]                   totalCount,
`ifdef PCOEFF_ECC_STICKY_EN
  output logic                          eccErrorSticky,
  output logic [15:0]                   eccErrorCount,
`endif
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
  localparam int unsigned DATA_W = SEQ_W + RESULT_W;

  logic                 w_grab;
  logic                 w_pop;
  pcoeff_result_t       w_result;
  logic [SEQ_W-1:0]     w_store_seq;
  logic [SEQ_W-1:0]     r_seq;
  logic [TOT_W-1:0]     r_total_sum;
  logic [31:0]          r_total_count;

  // Fullness is judged on registered occupancy, so a pop never frees a slot in the same cycle.
  assign w_grab      = rst && resultsAvailable && (occupancy < OCC_W'(DEPTH));
  assign grabResults = w_grab;
  assign w_pop       = outValid && outReady;

  assign w_result.ecc   = eccStatus;
  assign w_result.count = pcoeffCount;
  assign w_result.sum   = pcoeffSum;
  assign w_store_seq    = clearTotals ? '0 : r_seq;

  pcoeff_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_grab),
    .i_data      ({w_store_seq, w_result}),
    .i_pop       (w_pop),
    .o_valid     (outValid),
    .o_data      (outData),
    .o_occupancy (occupancy)
  );

  // A clear concurrent with a grab restarts the totals from that result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq         <= '0;
      r_total_sum   <= '0;
      r_total_count <= '0;
    end else if (clearTotals) begin
      r_seq         <= w_grab ? SEQ_W'(1) : '0;
      r_total_sum   <= w_grab ? TOT_W'(pcoeffSum) : '0;
      r_total_count <= w_grab ? 32'd1 : 32'd0;
    end else if (w_grab) begin
      r_seq         <= r_seq + SEQ_W'(1);
      r_total_sum   <= r_total_sum + TOT_W'(pcoeffSum);
      r_total_count <= r_total_count + 32'd1;
    end
  end

  assign totalSum   = r_total_sum;
  assign totalCount = r_total_count;

`ifdef PCOEFF_ECC_STICKY_EN
  logic        r_ecc_sticky;
  logic [15:0] r_ecc_count;
  logic        w_ecc_hit;

  assign w_ecc_hit = w_grab && eccStatus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ecc_sticky <= 1'b0;
      r_ecc_count  <= '0;
    end else if (clearTotals) begin
      r_ecc_sticky <= w_ecc_hit;
      r_ecc_count  <= w_ecc_hit ? 16'd1 : 16'd0;
    end else if (w_ecc_hit) begin
      r_ecc_sticky <= 1'b1;
      if (r_ecc_count != 16'hFFFF) begin
        r_ecc_count <= r_ecc_count + 16'd1;
      end
    end
  end

  assign eccErrorSticky = r_ecc_sticky;
  assign eccErrorCount  = r_ecc_count;
`endif

endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Bench for pcoeff_result_collector: directed table, corner sequences and a queue-based model.
// Define PCOEFF_ECC_STICKY_EN to also exercise the ECC statistics ports.
module tb_pcoeff_result_collector;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ra;
  logic [47:0] sum_in;
  logic [12:0] cnt_in;
  logic        ecc_in;
  logic        rdy;
  logic        clr;
  logic        grab;
  logic        out_valid;
  logic [77:0] out_data;
  logic [63:0] tot_sum;
  logic [31:0] tot_cnt;
  logic [3:0]  occ;
`ifdef PCOEFF_ECC_STICKY_EN
  logic        ecc_sticky;
  logic [15:0] ecc_count;
`endif

  always #5 clk = ~clk;

  pcoeff_result_collector dut (
    .clk              (clk),
    .rst              (rst),
    .resultsAvailable (ra),
    .pcoeffSum        (sum_in),
    .pcoeffCount      (cnt_in),
    .eccStatus        (ecc_in),
    .grabResults      (grab),
    .outValid         (out_valid),
    .outReady         (rdy),
    .outData          (out_data),
    .clearTotals      (clr),
    .totalSum         (tot_sum),
    .totalCount       (tot_cnt),
`ifdef PCOEFF_ECC_STICKY_EN
    .eccErrorSticky   (ecc_sticky),
    .eccErrorCount    (ecc_count),
`endif
    .occupancy        (occ)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: the FIFO is a queue of whole output words.
  logic [77:0] m_q[$];
  logic [15:0] m_seq;
  logic [63:0] m_tsum;
  logic [31:0] m_tcnt;
  logic        m_sticky;
  logic [15:0] m_ecnt;

  typedef struct {
    logic        ra;
    logic [47:0] sum;
    logic [12:0] cnt;
    logic        ecc;
    logic        rdy;
    logic        clr;
    logic        e_grab;
    logic        e_valid;
    logic [77:0] e_data;
    logic [3:0]  e_occ;
    logic [63:0] e_tsum;
    logic [31:0] e_tcnt;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_seq    = '0;
    m_tsum   = '0;
    m_tcnt   = '0;
    m_sticky = 1'b0;
    m_ecnt   = '0;
  endtask

  task automatic model_check();
    chk("grab", 128'(grab), 128'(ra && (m_q.size() < DEPTH)));
    chk("valid", 128'(out_valid), 128'(m_q.size() != 0));
    if (m_q.size() != 0) chk("data", 128'(out_data), 128'(m_q[0]));
    chk("occ", 128'(occ), 128'(m_q.size()));
    chk("tsum", 128'(tot_sum), 128'(m_tsum));
    chk("tcnt", 128'(tot_cnt), 128'(m_tcnt));
`ifdef PCOEFF_ECC_STICKY_EN
    chk("sticky", 128'(ecc_sticky), 128'(m_sticky));
    chk("ecnt", 128'(ecc_count), 128'(m_ecnt));
`endif
  endtask

  // Applies the current inputs to the model for one clock edge, then advances to the next negedge.
  task automatic advance();
    logic g;
    logic p;
    g = ra && (m_q.size() < DEPTH);
    p = (m_q.size() != 0) && rdy;
    if (p) void'(m_q.pop_front());
    if (g) m_q.push_back({clr ? 16'h0 : m_seq, ecc_in, cnt_in, sum_in});
    if (clr) begin
      m_seq = g ? 16'd1 : 16'd0;
      m_tsum = '0;
      m_tcnt = '0;
      m_sticky = 1'b0;
      m_ecnt = '0;
    end else if (g) begin
      m_seq = m_seq + 16'd1;
    end
    if (g) begin
      m_tsum = m_tsum + {16'h0, sum_in};
      m_tcnt = m_tcnt + 32'd1;
      if (ecc_in) begin
        m_sticky = 1'b1;
        if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic [47:0] s, input logic [12:0] c,
                       input logic e, input logic r, input logic cl);
    ra = a; sum_in = s; cnt_in = c; ecc_in = e; rdy = r; clr = cl;
    #1;
  endtask

  task automatic step(input logic a, input logic [47:0] s, input logic [12:0] c,
                      input logic e, input logic r, input logic cl);
    drive(a, s, c, e, r, cl);
    model_check();
    advance();
  endtask

  vec_t tbl[6];
  int   grabs;
  logic [77:0] w;

  initial begin
    tbl[0] = '{1'b1, 48'h1234, 13'd120, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 78'h0, 4'd0, 64'h0, 32'd0};
    tbl[1] = '{1'b0, 48'h0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               {16'h0, 1'b0, 13'd120, 48'h1234}, 4'd1, 64'h1234, 32'd1};
    tbl[2] = '{1'b1, 48'h5, 13'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
               {16'h0, 1'b0, 13'd120, 48'h1234}, 4'd1, 64'h1234, 32'd1};
    tbl[3] = '{1'b0, 48'h0, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
               {16'h0, 1'b0, 13'd120, 48'h1234}, 4'd2, 64'h5, 32'd1};
    tbl[4] = '{1'b0, 48'h0, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
               {16'h0, 1'b1, 13'd7, 48'h5}, 4'd1, 64'h5, 32'd1};
    tbl[5] = '{1'b0, 48'h0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 78'h0, 4'd0, 64'h5, 32'd1};

    // Power-on reset with resultsAvailable high: no grab may be issued.
    rst = 1'b0;
    ra = 1'b1; sum_in = '0; cnt_in = '0; ecc_in = 1'b0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    chk("rst_grab", 128'(grab), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_occ", 128'(occ), 128'(0));
    chk("rst_tsum", 128'(tot_sum), 128'(0));
    chk("rst_tcnt", 128'(tot_cnt), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single result, then clear concurrent with a grab.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].ra, tbl[i].sum, tbl[i].cnt, tbl[i].ecc, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_grab", i), 128'(grab), 128'(tbl[i].e_grab));
      chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), 128'(out_data), 128'(tbl[i].e_data));
      chk($sformatf("tbl%0d_occ", i), 128'(occ), 128'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_tsum", i), 128'(tot_sum), 128'(tbl[i].e_tsum));
      chk($sformatf("tbl%0d_tcnt", i), 128'(tot_cnt), 128'(tbl[i].e_tcnt));
      advance();
    end

    // Asynchronous reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 48'(i + 100), 13'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 48'h77, 13'd1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_occ", 128'(occ), 128'(3));
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_occ", 128'(occ), 128'(0));
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_tsum", 128'(tot_sum), 128'(0));
    chk("mid_rst_tcnt", 128'(tot_cnt), 128'(0));
    chk("mid_rst_grab", 128'(grab), 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Fill to DEPTH with the consumer stalled, then release it.
    grabs = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 48'(i * 3), 13'(i), 1'b0, 1'b0, 1'b0);
      if (grab) grabs++;
      model_check();
      advance();
    end
    chk("fill_grabs", 128'(grabs), 128'(8));
    drive(1'b1, 48'h99, 13'd9, 1'b0, 1'b0, 1'b0);
    chk("fill_occ", 128'(occ), 128'(8));
    chk("fill_nograb", 128'(grab), 128'(0));
    for (int k = 0; k < 8; k++) begin
      drive(k < 2, 48'h99, 13'd9, 1'b0, 1'b1, 1'b0);
      w = out_data;
      chk($sformatf("drain_seq%0d", k), 128'(w[77:62]), 128'(k));
      if (k == 0) chk("full_pop_nograb", 128'(grab), 128'(0));
      if (k == 1) chk("grab_after_pop", 128'(grab), 128'(1));
      model_check();
      advance();
    end
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Sequence tag wrap: stream 65535 results through, then two more.
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 48'({$urandom(), $urandom()}), 13'($urandom()), 1'b0, 1'b1, 1'b0);
      model_check();
      advance();
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 13'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 13'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    w = out_data;
    chk("wrap_seq_ffff", 128'(w[77:62]), 128'(16'hFFFF));
    model_check();
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    w = out_data;
    chk("wrap_seq_0000", 128'(w[77:62]), 128'(0));
    model_check();
    advance();

    // Total accumulation beyond 48 bits.
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 13'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 13'd4, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("tsum_carry", 128'(tot_sum), 128'(64'h1_FFFF_FFFF_FFFE));
    chk("tcnt_two", 128'(tot_cnt), 128'(2));
    model_check();
    advance();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // ECC bit carried per entry; statistics when enabled.
    step(1'b1, 48'h11, 13'd1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 48'h22, 13'd2, 1'b0, 1'b1, 1'b0);
    w = out_data;
    chk("ecc_bit_out", 128'(w[61]), 128'(1));
    model_check();
    advance();
    step(1'b1, 48'h33, 13'd3, 1'b1, 1'b1, 1'b0);
`ifdef PCOEFF_ECC_STICKY_EN
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("ecc_sticky", 128'(ecc_sticky), 128'(1));
    chk("ecc_count", 128'(ecc_count), 128'(2));
    model_check();
    advance();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("ecc_sticky_clr", 128'(ecc_sticky), 128'(0));
    chk("ecc_count_clr", 128'(ecc_count), 128'(0));
    model_check();
    advance();
`endif
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 48'({$urandom(), $urandom()}), 13'($urandom()),
           1'($urandom()), 1'($urandom()), $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
